// File: rtl/sram_burst_ctrl.sv
// Single-port SRAM with command-driven burst reads/writes, auto-incrementing
// wrapping address, abort on slave-select release, and an illegal-command pulse.
module sram_burst_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int BLEN_W = 4
) (
  input  logic              sck,
  input  logic              rst_n,
  input  logic              ss,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BLEN_W-1:0] burst_len,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_cur;
  logic [ADDR_W-1:0]   w_cur_next;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [BLEN_W-1:0]   r_rem;
  logic [BLEN_W-1:0]   w_rem_next;
  logic                w_rd_en;
  logic                w_wr_en;
  logic                w_err;
  logic [DATA_W-1:0]   r_dout;
  logic                r_dout_valid;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  // Every edge performs at most one access: either the accepted command's
  // first beat (at the input address) or a continuation beat at r_cur.
  always_comb begin
    w_state_next = r_state;
    w_cur_next   = r_cur;
    w_rem_next   = r_rem;
    w_acc_addr   = r_cur;
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    w_err        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!ss) begin
          unique case ({we, re})
            2'b01: begin
              w_rd_en    = 1'b1;
              w_acc_addr = addr;
              w_cur_next = addr + 1'b1;
              w_rem_next = burst_len;
              if (burst_len != '0) w_state_next = S_RD;
            end
            2'b10: begin
              w_wr_en    = 1'b1;
              w_acc_addr = addr;
              w_cur_next = addr + 1'b1;
              w_rem_next = burst_len;
              if (burst_len != '0) w_state_next = S_WR;
            end
            2'b11:   w_err = 1'b1;
            default: ;
          endcase
        end
      end
      S_RD, S_WR: begin
        if (ss) begin
          w_state_next = S_IDLE;
        end else begin
          w_rd_en    = (r_state == S_RD);
          w_wr_en    = (r_state == S_WR);
          w_cur_next = r_cur + 1'b1;
          w_rem_next = r_rem - 1'b1;
          if (r_rem == BLEN_W'(1)) w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // The memory shares the reset process so that an edge seen while reset is
  // held can never commit a write; the array itself is left untouched.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      r_cur        <= '0;
      r_rem        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_cur        <= w_cur_next;
      r_rem        <= w_rem_next;
      r_dout_valid <= w_rd_en;
      r_err        <= w_err;
      if (w_rd_en) r_dout <= r_mem[w_acc_addr];
      if (w_wr_en) r_mem[w_acc_addr] <= din;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign err        = r_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: pending-beat queue model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_sram_burst_ctrl;

  logic       sck = 1'b0;
  logic       rst_n = 1'b0;
  logic       ss = 1'b1;
  logic       re = 1'b0;
  logic       we = 1'b0;
  logic [7:0] addr = '0;
  logic [3:0] burst_len = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       err;

  int n_cmp = 0;
  int n_err = 0;

  sram_burst_ctrl #(.DATA_W(8), .ADDR_W(8), .BLEN_W(4)) dut (
    .sck(sck), .rst_n(rst_n), .ss(ss), .re(re), .we(we), .addr(addr),
    .burst_len(burst_len), .din(din), .dout(dout), .dout_valid(dout_valid),
    .busy(busy), .err(err)
  );

  always #5 sck = ~sck;

  // Model: memory image plus a queue of addresses still owed by the burst.
  logic [7:0] m_mem [256];
  logic [7:0] m_q [$];
  bit         m_rd = 1'b0;
  logic [7:0] m_a;
  logic [7:0] e_dout = '0;
  bit         e_dv = 1'b0;
  bit         e_err = 1'b0;
  bit         e_busy = 1'b0;

  initial for (int i = 0; i < 256; i++) m_mem[i] = '0;

  always @(posedge sck) begin
    if (rst_n) begin
      e_dv  = 1'b0;
      e_err = 1'b0;
      if (m_q.size() != 0) begin
        if (ss) begin
          m_q.delete();
        end else begin
          m_a = m_q.pop_front();
          if (m_rd) begin e_dout = m_mem[m_a]; e_dv = 1'b1; end
          else m_mem[m_a] = din;
        end
      end else if (!ss) begin
        if (re && we) begin
          e_err = 1'b1;
        end else if (re || we) begin
          m_rd = re;
          if (re) begin e_dout = m_mem[addr]; e_dv = 1'b1; end
          else m_mem[addr] = din;
          for (int i = 1; i <= int'(burst_len); i++) m_q.push_back(8'(int'(addr) + i));
        end
      end
      e_busy = (m_q.size() != 0);
    end
  end

  always @(negedge rst_n) begin
    m_q.delete();
    e_dout = '0; e_dv = 1'b0; e_err = 1'b0; e_busy = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge sck) begin
    chk("model dout", 32'(dout), 32'(e_dout));
    chk("model dout_valid", 32'(dout_valid), 32'(e_dv));
    chk("model busy", 32'(busy), 32'(e_busy));
    chk("model err", 32'(err), 32'(e_err));
  end

  task automatic cyc(input bit i_ss, input bit i_re, input bit i_we,
                     input logic [7:0] a, input logic [3:0] l, input logic [7:0] d);
    ss = i_ss; re = i_re; we = i_we; addr = a; burst_len = l; din = d;
    if (!i_ss && (i_re || i_we))
      $display("txn t=%0t ss=%0b re=%0b we=%0b addr=%02h len=%0d din=%02h",
               $time, i_ss, i_re, i_we, a, l, d);
    @(negedge sck);
  endtask

  logic [7:0] old43, old44, old45;

  initial begin
    // Reset state
    #1;
    chk("reset dout", 32'(dout), 32'h0);
    chk("reset dout_valid", 32'(dout_valid), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    repeat (3) @(negedge sck);
    rst_n = 1'b1;

    // Fill every word so the array contents are known to the model
    for (int b = 0; b < 16; b++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'(b * 16), 4'd15, 8'($urandom));
      for (int k = 0; k < 15; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'($urandom));
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);

    // 1: single write then single read
    cyc(1'b0, 1'b0, 1'b1, 8'h10, 4'd0, 8'hA5);
    chk("t1 busy after write", 32'(busy), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'h10, 4'd0, 8'h00);
    chk("t1 read dout", 32'(dout), 32'hA5);
    chk("t1 read valid", 32'(dout_valid), 32'h1);
    chk("t1 busy after read", 32'(busy), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    chk("t1 valid drops", 32'(dout_valid), 32'h0);

    // 2: wrapping write burst, then read it back
    cyc(1'b0, 1'b0, 1'b1, 8'hFE, 4'd3, 8'h11);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h22);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h33);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h44);
    chk("t2 write done busy", 32'(busy), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'hFE, 4'd3, 8'h00);
    chk("t2 beat0", 32'({dout_valid, dout}), 32'h111);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    chk("t2 beat1", 32'({dout_valid, dout}), 32'h122);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    chk("t2 beat2 wrapped", 32'({dout_valid, dout}), 32'h133);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    chk("t2 beat3", 32'({dout_valid, dout}), 32'h144);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    chk("t2 valid after burst", 32'(dout_valid), 32'h0);

    // 3: illegal command
    cyc(1'b0, 1'b1, 1'b1, 8'h10, 4'd2, 8'h5A);
    chk("t3 err pulse", 32'(err), 32'h1);
    chk("t3 busy", 32'(busy), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    chk("t3 err one cycle", 32'(err), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'h10, 4'd0, 8'h00);
    chk("t3 memory unchanged", 32'(dout), 32'hA5);

    // 4: read burst aborted after three beats
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 4'd7, 8'h00);
    chk("t4 beat0", 32'({dout_valid, dout}), 32'h133);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    chk("t4 beat1", 32'({dout_valid, dout}), 32'h144);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    chk("t4 beat2 valid", 32'(dout_valid), 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    chk("t4 abort valid", 32'(dout_valid), 32'h0);
    chk("t4 abort busy", 32'(busy), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'hFE, 4'd0, 8'h00);
    chk("t4 next command", 32'({dout_valid, dout}), 32'h111);

    // 5: reset during a write burst
    old43 = m_mem[8'h43]; old44 = m_mem[8'h44]; old45 = m_mem[8'h45];
    cyc(1'b0, 1'b0, 1'b1, 8'h40, 4'd5, 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h02);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h03);
    chk("t5 busy before reset", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    we = 1'b1; addr = 8'h43; din = 8'hEE;
    #1;
    chk("t5 reset dout", 32'(dout), 32'h0);
    chk("t5 reset valid", 32'(dout_valid), 32'h0);
    chk("t5 reset busy", 32'(busy), 32'h0);
    @(negedge sck);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 8'h40, 4'd5, 8'h00);
    chk("t5 rd beat0", 32'(dout), 32'h01);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    chk("t5 rd beat1", 32'(dout), 32'h02);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    chk("t5 rd beat2", 32'(dout), 32'h03);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    chk("t5 rd beat3 unwritten", 32'(dout), 32'(old43));
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    chk("t5 rd beat4 unwritten", 32'(dout), 32'(old44));
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    chk("t5 rd beat5 unwritten", 32'(dout), 32'(old45));

    // 6: commands ignored while a read burst runs
    cyc(1'b0, 1'b1, 1'b0, 8'hFE, 4'd3, 8'h00);
    chk("t6 beat0", 32'({dout_valid, dout}), 32'h111);
    cyc(1'b0, 1'b0, 1'b1, 8'hFE, 4'd0, 8'h99);
    chk("t6 beat1", 32'({err, dout_valid, dout}), 32'h122);
    cyc(1'b0, 1'b1, 1'b1, 8'hFE, 4'd0, 8'h99);
    chk("t6 beat2", 32'({err, dout_valid, dout}), 32'h133);
    cyc(1'b0, 1'b0, 1'b1, 8'hFE, 4'd0, 8'h99);
    chk("t6 beat3", 32'({err, dout_valid, dout}), 32'h144);
    chk("t6 burst complete", 32'(busy), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'hFE, 4'd0, 8'h00);
    chk("t6 no stray write", 32'(dout), 32'h11);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      cyc(($urandom_range(0, 9) == 0), (sel <= 3) || (sel == 8),
          ((sel >= 4) && (sel <= 7)) || (sel == 8),
          8'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3)),
          8'($urandom));
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
